// File: rtl/contador_hex.sv
// Hex count stage for the seven-segment display path: button sync/edge detect,
// run/pause FSM, prescaler and up/down counter. Define CONT_DEBOUNCE_EN to add button debouncers.
module contador_hex #(
  parameter int unsigned DIV       = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       up_dn,
  output logic [3:0] cont,
  output logic       tc,
  output logic       running
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned NB = 2;

  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_e;

  if (DIV < 1 || DB_CYCLES < 1) begin : g_bad_param
    $error("contador_hex: DIV and DB_CYCLES must be >= 1");
  end

  // Bit order {up_dn, btn_clr, btn_run}; button index 0 = run, 1 = clr.
  logic [2:0]    sync1_q, sync2_q;
  logic [1:0]    vld_q;
  logic [NB-1:0] lvl_c, lvl_prev_q, arm_q, arm_d, pulse_c;

  // A button only arms once it has been seen released after reset, so a
  // button held through reset release cannot produce a pulse.
  always_comb begin
    arm_d   = arm_q | ({NB{vld_q[1]}} & ~sync2_q[NB-1:0]);
    pulse_c = lvl_c & ~lvl_prev_q & arm_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      vld_q      <= '0;
      arm_q      <= '0;
      lvl_prev_q <= '0;
    end else begin
      sync1_q    <= {up_dn, btn_clr, btn_run};
      sync2_q    <= sync1_q;
      vld_q      <= {vld_q[0], 1'b1};
      arm_q      <= arm_d;
      lvl_prev_q <= lvl_c;
    end
  end

`ifdef CONT_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DB_CYCLES + 1);

  logic [NB-1:0]         db_q, db_d;
  logic [NB-1:0][DW-1:0] db_cnt_q, db_cnt_d;

  // Accept a new level after DB_CYCLES consecutive mismatching cycles.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    for (int i = 0; i < int'(NB); i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DW'(DB_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q     <= '0;
      db_cnt_q <= '0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign lvl_c = db_q;
`else
  assign lvl_c = sync2_q[NB-1:0];
`endif

  logic          run_p, clr_p, up_s, tick_c;
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    cont_q, cont_d;
  logic          tc_q, tc_d;

  assign run_p  = pulse_c[0];
  assign clr_p  = pulse_c[1];
  assign up_s   = sync2_q[2];
  assign tick_c = (state_q == RUN) && (presc_q == PW'(DIV - 1));

  // Clear wins over tick; a tick in the cycle of a RUN->PAUSE toggle still applies.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cont_d  = cont_q;
    tc_d    = 1'b0;
    if (run_p) begin
      state_d = (state_q == RUN) ? PAUSE : RUN;
    end
    if (clr_p) begin
      presc_d = '0;
      cont_d  = '0;
    end else if (tick_c) begin
      presc_d = '0;
      cont_d  = up_s ? (cont_q + 4'd1) : (cont_q - 4'd1);
      tc_d    = up_s ? (cont_q == 4'hF) : (cont_q == 4'h0);
    end else if (state_q == RUN) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PAUSE;
      presc_q <= '0;
      cont_q  <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cont_q  <= cont_d;
      tc_q    <= tc_d;
    end
  end

  assign cont    = cont_q;
  assign tc      = tc_q;
  assign running = (state_q == RUN);

endmodule
